// File: rtl/store_pkg.sv
// Shared definitions for the store alignment path: size encodings and FSM states.
package store_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane shifter: builds the double-width byte strobe and write data
// for a store of the given size placed at the given byte offset within a bus word.
module store_lane_shift
    import store_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [1:0]                size,
    input  logic [XLEN-1:0]           data,
    output logic [2*(XLEN/8)-1:0]     strobe,
    output logic [2*XLEN-1:0]         shifted
);

    localparam int NB = XLEN / 8;

    logic [1:0]      eff_size;
    logic [NB-1:0]   byte_en;
    logic [XLEN-1:0] masked;

    // Enable the low 2^size bytes, zero the rest, then slide both into position.
    always_comb begin
        eff_size = size;
        if (XLEN == 32 && size == SZ_D) begin
            eff_size = SZ_W;
        end
        byte_en = '0;
        masked  = '0;
        for (int i = 0; i < NB; i++) begin
            byte_en[i]       = (i < (1 << eff_size));
            masked[i*8 +: 8] = byte_en[i] ? data[i*8 +: 8] : 8'h00;
        end
        strobe  = {{NB{1'b0}}, byte_en} << offset;
        shifted = {{XLEN{1'b0}}, masked} << {offset, 3'b000};
    end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts a byte-addressed store and issues one or two
// aligned bus beats with lane-aligned data and byte strobes.
module store_align_unit
    import store_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic [XLEN-1:0]     req_data,
    input  logic [1:0]          req_size,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [31:0]         mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic                done,
    output logic                misalign_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    state_t state, state_next;

    logic [2*NB-1:0]   full_strb;
    logic [2*XLEN-1:0] full_data;
    logic              upper_nz;
    logic [NB-1:0]     hold_strb;
    logic [XLEN-1:0]   hold_data;
    logic              accept;
    logic              reject;
    logic              go_beat1;
    logic              finish;

    store_lane_shift #(.XLEN(XLEN)) u_shift (
        .offset  (req_addr[OFFW-1:0]),
        .size    (req_size),
        .data    (req_data),
        .strobe  (full_strb),
        .shifted (full_data)
    );

    assign upper_nz  = |full_strb[2*NB-1:NB];
    assign req_ready = (state == IDLE);
    assign mem_valid = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the per-cycle events that steer the datapath.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        go_beat1   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (upper_nz && SPLIT_MISALIGNED == 0) begin
                        reject = 1'b1;
                        finish = 1'b1;
                    end else begin
                        state_next = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    if (|hold_strb) begin
                        go_beat1   = 1'b1;
                        state_next = BEAT1;
                    end else begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat registers: load beat0 on acceptance, swap in beat1, clear when finished.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            hold_strb    <= '0;
            hold_data    <= '0;
            done         <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            done         <= finish;
            misalign_err <= reject;
            if (accept && !reject) begin
                mem_addr  <= {req_addr[31:OFFW], {OFFW{1'b0}}};
                mem_wdata <= full_data[XLEN-1:0];
                mem_wstrb <= full_strb[NB-1:0];
                hold_data <= full_data[2*XLEN-1:XLEN];
                hold_strb <= full_strb[2*NB-1:NB];
            end else if (go_beat1) begin
                mem_addr  <= mem_addr + 32'(NB);
                mem_wdata <= hold_data;
                mem_wstrb <= hold_strb;
            end else if (finish) begin
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_wstrb <= '0;
                hold_data <= '0;
                hold_strb <= '0;
            end
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed testbench for store_align_unit (XLEN=32), with a split and a non-split instance.
module tb_store_align_unit;

    logic        clk;
    logic        reset;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        misalign_err;

    logic        ns_req_valid;
    logic        ns_req_ready;
    logic [31:0] ns_req_addr;
    logic [31:0] ns_req_data;
    logic [1:0]  ns_req_size;
    logic        ns_mem_valid;
    logic        ns_mem_ready;
    logic [31:0] ns_mem_addr;
    logic [31:0] ns_mem_wdata;
    logic [3:0]  ns_mem_wstrb;
    logic        ns_done;
    logic        ns_misalign_err;

    int check_count;
    int fail_count;

    store_align_unit #(.XLEN(32), .SPLIT_MISALIGNED(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_size     (req_size),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .done         (done),
        .misalign_err (misalign_err)
    );

    store_align_unit #(.XLEN(32), .SPLIT_MISALIGNED(0)) dut_ns (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (ns_req_valid),
        .req_ready    (ns_req_ready),
        .req_addr     (ns_req_addr),
        .req_data     (ns_req_data),
        .req_size     (ns_req_size),
        .mem_valid    (ns_mem_valid),
        .mem_ready    (ns_mem_ready),
        .mem_addr     (ns_mem_addr),
        .mem_wdata    (ns_mem_wdata),
        .mem_wstrb    (ns_mem_wstrb),
        .done         (ns_done),
        .misalign_err (ns_misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Offer one request to the split instance; caller is at a negedge, returns just after the accepting posedge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Same as applyStimulus for the non-split instance.
    task automatic applyStimulusNs(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        ns_req_valid = 1'b1;
        ns_req_addr  = addr;
        ns_req_data  = data;
        ns_req_size  = size;
        @(posedge clk);
        #1;
        ns_req_valid = 1'b0;
    endtask

    // Check one presented beat of the split instance.
    task automatic checkBeat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        checkOutput({tag, "_valid"}, 64'(mem_valid), 64'(1));
        checkOutput({tag, "_addr"},  64'(mem_addr),  64'(a));
        checkOutput({tag, "_wdata"}, 64'(mem_wdata), 64'(d));
        checkOutput({tag, "_wstrb"}, 64'(mem_wstrb), 64'(s));
        checkOutput({tag, "_nodone"}, 64'(done), 64'(0));
    endtask

    // Check the completion cycle of the split instance.
    task automatic checkDone(input string tag);
        checkOutput({tag, "_done"},   64'(done),         64'(1));
        checkOutput({tag, "_noerr"},  64'(misalign_err), 64'(0));
        checkOutput({tag, "_idle"},   64'(mem_valid),    64'(0));
        checkOutput({tag, "_ready"},  64'(req_ready),    64'(1));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        check_count  = 0;
        fail_count   = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_data     = '0;
        req_size     = '0;
        mem_ready    = 1'b1;
        ns_req_valid = 1'b0;
        ns_req_addr  = '0;
        ns_req_data  = '0;
        ns_req_size  = '0;
        ns_mem_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 64'(mem_valid),    64'(0));
        checkOutput("rst_done",  64'(done),         64'(0));
        checkOutput("rst_err",   64'(misalign_err), 64'(0));
        checkOutput("rst_addr",  64'(mem_addr),     64'(0));
        checkOutput("rst_wdata", 64'(mem_wdata),    64'(0));
        checkOutput("rst_wstrb", 64'(mem_wstrb),    64'(0));
        checkOutput("rst_ready", 64'(req_ready),    64'(1));
        reset = 1'b0;
        @(negedge clk);

        // sb at offset 3
        applyStimulus(32'h0000_1003, 32'hAABB_CCDD, 2'b00);
        @(negedge clk);
        checkBeat("sb", 32'h0000_1000, 32'hDD00_0000, 4'b1000);
        @(negedge clk);
        checkDone("sb");

        // sh at offset 2, then an aligned sw issued in the done cycle
        applyStimulus(32'h0000_1002, 32'h0000_1234, 2'b01);
        @(negedge clk);
        checkBeat("sh", 32'h0000_1000, 32'h1234_0000, 4'b1100);
        @(negedge clk);
        checkDone("sh");
        applyStimulus(32'h0000_3000, 32'h5566_7788, 2'b10);
        @(negedge clk);
        checkBeat("b2b", 32'h0000_3000, 32'h5566_7788, 4'b1111);
        @(negedge clk);
        checkDone("b2b");

        // misaligned sw split into two beats
        applyStimulus(32'h0000_2001, 32'h1122_3344, 2'b10);
        @(negedge clk);
        checkBeat("sw0", 32'h0000_2000, 32'h2233_4400, 4'b1110);
        @(negedge clk);
        checkBeat("sw1", 32'h0000_2004, 32'h0000_0011, 4'b0001);
        @(negedge clk);
        checkDone("sw");

        // same store rejected by the non-split instance
        applyStimulusNs(32'h0000_2001, 32'h1122_3344, 2'b10);
        @(negedge clk);
        checkOutput("ns_done",  64'(ns_done),         64'(1));
        checkOutput("ns_err",   64'(ns_misalign_err), 64'(1));
        checkOutput("ns_nobus", 64'(ns_mem_valid),    64'(0));
        checkOutput("ns_ready", 64'(ns_req_ready),    64'(1));
        @(negedge clk);
        checkOutput("ns_done_pulse", 64'(ns_done),         64'(0));
        checkOutput("ns_err_pulse",  64'(ns_misalign_err), 64'(0));
        checkOutput("ns_nobus2",     64'(ns_mem_valid),    64'(0));

        // aligned sw on the non-split instance still goes to the bus
        applyStimulusNs(32'h0000_4004, 32'hDEAD_BEEF, 2'b10);
        @(negedge clk);
        checkOutput("ns_al_valid", 64'(ns_mem_valid),    64'(1));
        checkOutput("ns_al_addr",  64'(ns_mem_addr),     64'(32'h0000_4004));
        checkOutput("ns_al_wdata", 64'(ns_mem_wdata),    64'(32'hDEAD_BEEF));
        checkOutput("ns_al_err",   64'(ns_misalign_err), 64'(0));
        @(negedge clk);
        checkOutput("ns_al_done",  64'(ns_done),         64'(1));
        checkOutput("ns_al_noerr", 64'(ns_misalign_err), 64'(0));

        // stall beat0 for three cycles, then wrap the beat1 address
        mem_ready = 1'b0;
        applyStimulus(32'hFFFF_FFFE, 32'hCAFE_BABE, 2'b10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkBeat("stall", 32'hFFFF_FFFC, 32'hBABE_0000, 4'b1100);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checkBeat("wrap1", 32'h0000_0000, 32'h0000_CAFE, 4'b0011);
        @(negedge clk);
        checkDone("wrap");

        // reset while beat1 is presented
        applyStimulus(32'h0000_2001, 32'h1122_3344, 2'b10);
        @(negedge clk);
        checkBeat("rb0", 32'h0000_2000, 32'h2233_4400, 4'b1110);
        @(negedge clk);
        checkBeat("rb1", 32'h0000_2004, 32'h0000_0011, 4'b0001);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mrst_valid", 64'(mem_valid), 64'(0));
        checkOutput("mrst_done",  64'(done),      64'(0));
        checkOutput("mrst_ready", 64'(req_ready), 64'(1));
        checkOutput("mrst_wstrb", 64'(mem_wstrb), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mrst_done2",  64'(done),      64'(0));
        checkOutput("mrst_valid2", 64'(mem_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
